vit_dec_sched: RTL and testbench

//  Frame scheduler sharing one vit_dec among pCH_NUM channel frame buffers. Round-robin grants a

---
 rtl/vit_dec_sched_pkg.sv | 17 +
 rtl/vit_dec_sched_rr_arb.sv | 43 ++++
 rtl/vit_dec_sched.sv | 190 +++++++++++++++++++
 tb/tb_vit_dec_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_dec_sched_pkg.sv
// Shared types and helpers for the frame scheduler that feeds one Viterbi decoder from several channel buffers.
package vit_dec_sched_pkg;

    localparam int CH_NUM_DEF = 4;
    localparam int LEN_W_DEF  = 12;

    typedef enum logic [1:0] {IDLE, ARB, READ, GAP} state_t;

    typedef logic [$clog2(CH_NUM_DEF)-1:0] ch_idx_t;
    typedef logic [LEN_W_DEF-1:0]          len_t;

    // Bit offset of code bit g of channel ch inside a flattened per-channel LLR bus
    function automatic int llr_base(int ch, int g, int gen_num, int llr_w);
        return (ch * gen_num + g) * llr_w;
    endfunction

endpackage

// File: rtl/vit_dec_sched_rr_arb.sv
// Round-robin selector: combinational one-hot pick starting at the pointer, pointer moves past each accepted winner.
module vit_dec_sched_rr_arb #(
    parameter int pCH_NUM = 4
) (
    input  logic                       iclk,
    input  logic                       ireset,
    input  logic                       iclkena,
    input  logic [pCH_NUM-1:0]         ireq,
    input  logic                       iadvance,
    output logic [pCH_NUM-1:0]         ogrant,
    output logic [$clog2(pCH_NUM)-1:0] oidx,
    output logic                       ovalid
);

    localparam int IDX_W = $clog2(pCH_NUM);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int c;
        c      = 0;
        ogrant = '0;
        oidx   = '0;
        ovalid = 1'b0;
        for (int i = 0; i < pCH_NUM; i++) begin
            c = (int'(ptr) + i) % pCH_NUM;
            if (!ovalid && ireq[c]) begin
                ovalid    = 1'b1;
                ogrant[c] = 1'b1;
                oidx      = IDX_W'(c);
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            ptr <= '0;
        end else if (iclkena && iadvance && ovalid) begin
            ptr <= (oidx == IDX_W'(pCH_NUM - 1)) ? '0 : oidx + 1'b1;
        end
    end

endmodule

// File: rtl/vit_dec_sched.sv
// Shares one vit_dec among several channel frame buffers: grants frames round-robin, streams them
// into the decoder, bounds frames in flight and routes decoder completions back by tag.
module vit_dec_sched
    import vit_dec_sched_pkg::*;
#(
    parameter int pCH_NUM       = CH_NUM_DEF,
    parameter int pCODE_GEN_NUM = 2,
    parameter int pLLR_W        = 4,
    parameter int pLEN_W        = LEN_W_DEF,
    parameter int pTAG_W        = 4,
    parameter int pERR_CNT_W    = 16,
    parameter int pGAP          = 2,
    parameter int pMAX_INFLIGHT = 2
) (
    input  logic                                    iclk,
    input  logic                                    ireset,
    input  logic                                    iclkena,
    input  logic [pCH_NUM-1:0]                      ireq,
    input  logic [pLEN_W*pCH_NUM-1:0]               ilen,
    output logic [pCH_NUM-1:0]                      ogrant,
    output logic [pCH_NUM-1:0]                      ordreq,
    output logic [pLEN_W-1:0]                       ordaddr,
    input  logic [pCODE_GEN_NUM*pCH_NUM-1:0]        ibuf_dat,
    input  logic [pLLR_W*pCODE_GEN_NUM*pCH_NUM-1:0] ibuf_LLR,
    output logic                                    odec_sop,
    output logic                                    odec_val,
    output logic                                    odec_eop,
    output logic [pTAG_W-1:0]                       odec_tag,
    output logic [pCODE_GEN_NUM-1:0]                odec_dat,
    output logic [pLLR_W*pCODE_GEN_NUM-1:0]         odec_LLR,
    input  logic                                    idec_oeop,
    input  logic [pTAG_W-1:0]                       idec_otag,
    input  logic [pERR_CNT_W-1:0]                   idec_oerrcnt,
    output logic [pCH_NUM-1:0]                      odone,
    output logic [pERR_CNT_W-1:0]                   oerrcnt,
    output logic [pCH_NUM-1:0]                      oerr_len
);

    localparam int IDX_W = $clog2(pCH_NUM);
    localparam int GAP_W = $clog2(pGAP + 1);
    localparam int INF_W = $clog2(pMAX_INFLIGHT + 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ch_q;
    logic [pLEN_W-1:0]  len_q;
    logic [pLEN_W-1:0]  addr_q;
    logic [GAP_W-1:0]   gap_q;
    logic [INF_W-1:0]   inflight;
    logic               rd_issue;
    logic               rd_first;
    logic               underflow;

    logic [pCH_NUM-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    logic [pLEN_W-1:0]  sel_len;

    vit_dec_sched_rr_arb #(
        .pCH_NUM (pCH_NUM)
    ) u_arb (
        .iclk     (iclk),
        .ireset   (ireset),
        .iclkena  (iclkena),
        .ireq     (ireq),
        .iadvance (state == ARB),
        .ogrant   (arb_gnt),
        .oidx     (arb_idx),
        .ovalid   (arb_vld)
    );

    assign sel_len  = ilen[int'(arb_idx)*pLEN_W +: pLEN_W];
    assign rd_first = rd_issue && (addr_q == '0);

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        ordreq    = '0;
        ordaddr   = '0;
        case (state)
            IDLE: begin
                if (ireq != '0 && inflight < INF_W'(pMAX_INFLIGHT))
                    state_nxt = ARB;
            end
            ARB: begin
                if (!arb_vld)
                    state_nxt = IDLE;
                else if (sel_len == '0)
                    state_nxt = GAP;
                else
                    state_nxt = READ;
            end
            READ: begin
                rd_issue     = 1'b1;
                ordreq[ch_q] = 1'b1;
                ordaddr      = addr_q;
                if (addr_q == len_q - 1'b1)
                    state_nxt = GAP;
            end
            GAP: begin
                if (gap_q == GAP_W'(pGAP - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state    <= IDLE;
            ch_q     <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            gap_q    <= '0;
            ogrant   <= '0;
            oerr_len <= '0;
        end else if (iclkena) begin
            state    <= state_nxt;
            ogrant   <= '0;
            oerr_len <= '0;
            case (state)
                ARB: begin
                    if (arb_vld) begin
                        ch_q   <= arb_idx;
                        len_q  <= sel_len;
                        addr_q <= '0;
                        gap_q  <= '0;
                        ogrant <= arb_gnt;
                        if (sel_len == '0)
                            oerr_len <= arb_gnt;
                    end
                end
                READ:    addr_q <= addr_q + 1'b1;
                GAP:     gap_q  <= gap_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Decoder strobes trail the read strobe by one cycle, matching the buffer read latency
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            odec_val <= 1'b0;
            odec_sop <= 1'b0;
            odec_eop <= 1'b0;
            odec_tag <= '0;
        end else if (iclkena) begin
            odec_val <= rd_issue;
            odec_sop <= rd_first;
            odec_eop <= rd_issue && (addr_q == len_q - 1'b1);
            if (rd_issue)
                odec_tag <= pTAG_W'(ch_q);
        end
    end

    // ch_q cannot change before the beat following the last read has been presented
    assign odec_dat = odec_val ? ibuf_dat[int'(ch_q)*pCODE_GEN_NUM +: pCODE_GEN_NUM] : '0;
    assign odec_LLR = odec_val ? ibuf_LLR[llr_base(int'(ch_q), 0, pCODE_GEN_NUM, pLLR_W) +: pLLR_W*pCODE_GEN_NUM] : '0;

    assign underflow = iclkena && idec_oeop && !rd_first && (inflight == '0);

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            inflight <= '0;
        end else if (iclkena) begin
            if (rd_first && !idec_oeop)
                inflight <= inflight + 1'b1;
            else if (!rd_first && idec_oeop && inflight != '0)
                inflight <= inflight - 1'b1;
        end
    end

    always @(posedge iclk) begin
        if (!ireset)
            assert (!underflow);
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            odone   <= '0;
            oerrcnt <= '0;
        end else if (iclkena) begin
            odone <= '0;
            if (idec_oeop && int'(idec_otag) < pCH_NUM) begin
                odone[idec_otag[IDX_W-1:0]] <= 1'b1;
                oerrcnt                     <= idec_oerrcnt;
            end
        end
    end

endmodule

// File: tb/tb_vit_dec_sched.sv
// Directed bench for vit_dec_sched: scoreboard queues for grants, decoder beats and completions,
// with a buffer model and a fixed-latency decoder responder.
module tb_vit_dec_sched;

    localparam int CH   = 4;
    localparam int G    = 2;
    localparam int LW   = 4;
    localparam int LENW = 12;
    localparam int TW   = 4;
    localparam int EW   = 16;
    localparam int LLRW = G * LW;

    logic               iclk = 1'b0;
    logic               ireset;
    logic               iclkena;
    logic [CH-1:0]      ireq;
    logic [LENW*CH-1:0] ilen;
    logic [CH-1:0]      ogrant;
    logic [CH-1:0]      ordreq;
    logic [LENW-1:0]    ordaddr;
    logic [G*CH-1:0]    ibuf_dat;
    logic [LLRW*CH-1:0] ibuf_LLR;
    logic               odec_sop;
    logic               odec_val;
    logic               odec_eop;
    logic [TW-1:0]      odec_tag;
    logic [G-1:0]       odec_dat;
    logic [LLRW-1:0]    odec_LLR;
    logic               idec_oeop;
    logic [TW-1:0]      idec_otag;
    logic [EW-1:0]      idec_oerrcnt;
    logic [CH-1:0]      odone;
    logic [EW-1:0]      oerrcnt;
    logic [CH-1:0]      oerr_len;

    vit_dec_sched #(
        .pCH_NUM       (CH),
        .pCODE_GEN_NUM (G),
        .pLLR_W        (LW),
        .pLEN_W        (LENW),
        .pTAG_W        (TW),
        .pERR_CNT_W    (EW),
        .pGAP          (2),
        .pMAX_INFLIGHT (2)
    ) dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .iclkena      (iclkena),
        .ireq         (ireq),
        .ilen         (ilen),
        .ogrant       (ogrant),
        .ordreq       (ordreq),
        .ordaddr      (ordaddr),
        .ibuf_dat     (ibuf_dat),
        .ibuf_LLR     (ibuf_LLR),
        .odec_sop     (odec_sop),
        .odec_val     (odec_val),
        .odec_eop     (odec_eop),
        .odec_tag     (odec_tag),
        .odec_dat     (odec_dat),
        .odec_LLR     (odec_LLR),
        .idec_oeop    (idec_oeop),
        .idec_otag    (idec_otag),
        .idec_oerrcnt (idec_oerrcnt),
        .odone        (odone),
        .oerrcnt      (oerrcnt),
        .oerr_len     (oerr_len)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int tag;
        int due;
    } resp_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          grant_cnt = 0;
    bit          resp_en   = 1'b0;
    bit          auto_drop = 1'b0;
    logic [7:0]  grant_q[$];
    logic [15:0] beat_q[$];
    logic [19:0] done_q[$];
    resp_t       resp_q[$];

    function automatic logic [G-1:0] exp_dat(int c, logic [LENW-1:0] a);
        return G'(c * 3 + int'(a));
    endfunction

    function automatic logic [LLRW-1:0] exp_llr(int c, logic [LENW-1:0] a);
        return LLRW'(c * 37 + int'(a) * 11 + 5);
    endfunction

    // Every channel buffer answers each read cycle with its own pattern for the current address
    always @(posedge iclk) begin
        for (int c = 0; c < CH; c++) begin
            ibuf_dat[c*G +: G]       <= exp_dat(c, ordaddr);
            ibuf_LLR[c*LLRW +: LLRW] <= exp_llr(c, ordaddr);
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({ogrant, ordreq, ordaddr, odec_sop, odec_val, odec_eop, odec_tag,
                    odec_dat, odec_LLR, odone, oerrcnt, oerr_len});
    endfunction

    task automatic check_output(string name, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_frame(int c, int len);
        grant_q.push_back({CH'(1 << c), (len == 0) ? CH'(1 << c) : CH'(0)});
        for (int a = 0; a < len; a++)
            beat_q.push_back({a == 0, a == len - 1, TW'(c), exp_dat(c, LENW'(a)), exp_llr(c, LENW'(a))});
    endtask

    // One clock: monitor outputs produced by an enabled edge, then act as the decoder
    task automatic tick();
        logic  en_edge;
        resp_t r;
        en_edge = iclkena;
        @(negedge iclk);
        cyc++;
        if (!ireset && en_edge) begin
            if (ogrant != '0 || oerr_len != '0) begin
                grant_cnt++;
                if (grant_q.size() == 0)
                    check_output("grant_unexpected", {ogrant, oerr_len}, 0);
                else
                    check_output("grant", {ogrant, oerr_len}, grant_q.pop_front());
                if (auto_drop)
                    ireq = ireq & ~ogrant;
            end
            if (odec_val) begin
                if (beat_q.size() == 0)
                    check_output("beat_unexpected", {1'b1, odec_sop, odec_eop, odec_tag, odec_dat, odec_LLR}, 0);
                else
                    check_output("beat", {odec_sop, odec_eop, odec_tag, odec_dat, odec_LLR}, beat_q.pop_front());
            end
            if (odone != '0) begin
                if (done_q.size() == 0)
                    check_output("done_unexpected", {odone, oerrcnt}, 0);
                else
                    check_output("done", {odone, oerrcnt}, done_q.pop_front());
            end
            if (resp_en && odec_val && odec_eop)
                resp_q.push_back('{tag: int'(odec_tag), due: cyc + 3});
        end
        idec_oeop = 1'b0;
        if (!ireset && iclkena && resp_q.size() != 0 && resp_q[0].due <= cyc) begin
            r            = resp_q.pop_front();
            idec_oeop    = 1'b1;
            idec_otag    = TW'(r.tag);
            idec_oerrcnt = EW'(r.tag * 7 + 3);
            if (r.tag < CH)
                done_q.push_back({CH'(1 << r.tag), EW'(r.tag * 7 + 3)});
        end
    endtask

    task automatic pulse_oeop(int tag, int err);
        idec_oeop    = 1'b1;
        idec_otag    = TW'(tag);
        idec_oerrcnt = EW'(err);
        if (tag < CH)
            done_q.push_back({CH'(1 << tag), EW'(err)});
        tick();
    endtask

    task automatic wait_grants(int target, int budget);
        int n = 0;
        while (grant_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_output("grant_count", grant_cnt, target);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while ((grant_q.size() + beat_q.size() + done_q.size() + resp_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check_output(name, grant_q.size() + beat_q.size() + done_q.size() + resp_q.size(), 0);
    endtask

    task automatic set_len(int c, int len);
        ilen[c*LENW +: LENW] = LENW'(len);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        ireset       = 1'b1;
        iclkena      = 1'b1;
        ireq         = '0;
        ilen         = '0;
        idec_oeop    = 1'b0;
        idec_otag    = '0;
        idec_oerrcnt = '0;
        repeat (3) @(negedge iclk);
        check_output("reset_outputs", all_outs(), 0);
        ireset = 1'b0;
        tick();
        tick();
        check_output("idle_outputs", all_outs(), 0);

        // Round-robin with every channel requesting
        resp_en = 1'b1;
        for (int c = 0; c < CH; c++)
            set_len(c, 3);
        push_frame(0, 3);
        push_frame(1, 3);
        push_frame(2, 3);
        push_frame(3, 3);
        push_frame(0, 3);
        ireq = 4'b1111;
        wait_grants(5, 300);
        ireq = '0;
        drain("rr_drain", 300);

        // Single frame on channel 1, length 5
        auto_drop = 1'b1;
        set_len(1, 5);
        push_frame(1, 5);
        ireq = 4'b0010;
        wait_grants(grant_cnt + 1, 60);
        check_output("first_read", {ordreq, ordaddr}, {4'b0010, 12'd0});
        tick();
        check_output("sop_latency", {odec_val, odec_sop, odec_eop, odec_tag}, {3'b110, 4'd1});
        drain("ch1_drain", 100);

        // Zero-length frame on channel 2 then single-step frame on channel 3
        set_len(2, 0);
        set_len(3, 1);
        push_frame(2, 0);
        push_frame(3, 1);
        ireq = 4'b1100;
        wait_grants(grant_cnt + 2, 80);
        drain("len_drain", 100);

        // Frames in flight capped at two while the decoder stays silent
        resp_en = 1'b0;
        set_len(0, 2);
        set_len(1, 2);
        set_len(2, 2);
        push_frame(0, 2);
        push_frame(1, 2);
        push_frame(2, 2);
        base = grant_cnt;
        ireq = 4'b0111;
        wait_grants(base + 2, 80);
        repeat (30) tick();
        check_output("inflight_hold", grant_cnt, base + 2);
        pulse_oeop(2, 7);
        check_output("errcnt_tag2", oerrcnt, 7);
        wait_grants(base + 3, 40);
        repeat (6) tick();
        pulse_oeop(9, 123);
        check_output("otag_ignored", odone, 0);
        check_output("errcnt_hold", oerrcnt, 7);
        pulse_oeop(1, 11);
        drain("inflight_drain", 60);

        // Clock-enable stall in the middle of a read burst
        ireset = 1'b1;
        tick();
        ireset  = 1'b0;
        resp_en = 1'b1;
        tick();
        set_len(3, 8);
        push_frame(3, 8);
        ireq = 4'b1000;
        wait_grants(grant_cnt + 1, 40);
        repeat (3) tick();
        check_output("pre_stall_addr", {ordreq, ordaddr}, {4'b1000, 12'd3});
        iclkena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("stall_addr", {ordreq, ordaddr}, {4'b1000, 12'd3});
        end
        iclkena = 1'b1;
        drain("stall_drain", 100);

        // Reset in the middle of a read burst drops the frame
        set_len(0, 10);
        push_frame(0, 10);
        ireq = 4'b0001;
        wait_grants(grant_cnt + 1, 40);
        tick();
        tick();
        ireset = 1'b1;
        #1;
        check_output("reset_mid_read", all_outs(), 0);
        grant_q.delete();
        beat_q.delete();
        done_q.delete();
        resp_q.delete();
        ireq = '0;
        tick();
        tick();
        ireset = 1'b0;
        repeat (10) tick();
        check_output("post_reset_quiet", {odec_val, ordreq, ogrant, odone}, 0);
        drain("final_drain", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
